ofmap_packer: RTL and testbench
===============================

# ofmap_packer

Write-side counterpart of the ifmap input FIFO. Takes variable-length byte segments of ofmap results from the PE array (1–8 bytes per beat) and packs them contiguously, LSB-first, into full 64-bit words for DRAM write-back. At end of layer it flushes the residue as a zero-padded final word and pulses `done`. It sits between the ofmap output stage and the testbench/DRAM write port.

## Interface
- `WORD_W`, 64, DRAM word width in bits (fixed; byte-granular packing).
- `ADDR_W`, 11, width of the output word index.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `clear` input 1: synchronous abort; same effect as `rst`.
- `inValid` input 1: input beat valid.
- `inData` input 64: payload; byte k is `inData[8k+7:8k]`, and bytes at index ≥ `inBytes` are ignored.
- `inBytes` input 4: number of valid bytes. 0 means no data. Values 9–15 are clamped to 8.
- `inLast` input 1: the beat is the last of the layer.
- `inReady` output 1: packer accepts a beat this cycle.
- `outValid` output 1: `outData` holds a word to write.
- `outData` output 64: packed word.
- `outAddr` output ADDR_W: word index of `outData` within the layer.
- `outReady` input 1: DRAM side accepts the word.
- `done` output 1: one-cycle pulse after the final word of a layer is accepted.

## Operation
- State:
  - 128-bit `buffer`.
  - `fill`: valid bytes in `buffer`, 5-bit, range 0..16.
  - FSM: RUN, FLUSH, DONE.
  - `outAddr` register.
- Reset and `clear`: RUN, `buffer`=0, `fill`=0, `outAddr`=0, `done`=0. Resulting outputs: `outValid`=0, `outData`=0, `inReady`=1.
- `inReady` = (state==RUN) && (`fill` ≤ 8).
- Input accept is `inValid && inReady`:
  - Valid bytes are written at `buffer[8*f +: 8*n]`, where n is the clamped `inBytes` and f is the post-output fill (below).
  - Bytes above n are not written; they stay zero.
- `outValid` = (`fill` ≥ 8) || (state==FLUSH && `fill` > 0).
- `outData` = `buffer[63:0]`. Unfilled bytes are zero.
- Output accept is `outValid && outReady`:
  - `buffer` >>= 64 (zero fill).
  - `fill` = max(`fill` − 8, 0).
  - `outAddr` += 1, wrapping 2^ADDR_W−1 → 0 silently.
- Simultaneous input and output accept in the same cycle:
  - Apply the output shift first, giving f = `fill` − 8.
  - Then insert the input at f; new `fill` = `fill` − 8 + n.
  - No byte is lost or duplicated.
- Transitions:
  - RUN → FLUSH on an accepted beat with `inLast`=1. The beat's bytes are packed normally, and n=0 is allowed.
  - FLUSH: `inReady`=0. Emit all full words, then one partial zero-padded word if `fill` > 0.
  - FLUSH → DONE when `fill` reaches 0, whether via the final output accept or because `fill` was already 0 on entry.
  - DONE: `done`=1 for exactly one cycle, `outValid`=0, `inReady`=0. Next state RUN with `outAddr`=0.
- `clear` or `rst` mid-layer drops buffered data and any pending word; no `done` pulse.
- `outValid` never drops without `outReady`. `outData` and `outAddr` are stable while `outValid`=1 and `outReady`=0.

## Timing
- All outputs are functions of registered state only. There is no combinational path from `inValid`, `inData`, or `outReady` to any output.
- Latency: a beat accepted at edge N that brings `fill` ≥ 8 gives `outValid`=1 in the cycle after edge N.
- Throughput: with sustained 8-byte beats and `outReady`=1, one word per cycle. `fill` holds at 8 after the first word.
- Backpressure: with `outReady`=0, input stalls once `fill` > 8. `fill` never exceeds 16.
- Flush latency: the final word appears ≤ 2 cycles after the `inLast` accept, given `outReady`=1. `done` follows one cycle after the final word accept.
- `inLast` with an empty buffer and n=0: FLUSH→DONE takes one cycle, then the `done` pulse.

## Structure
- Shared package holds:
  - `WORD_W`, `BUF_W`=128, `FILL_W`=5.
  - `MAX_BYTES`=8.
  - FSM enum {RUN, FLUSH, DONE}.
- One natural sub-module, `ofmap_byte_insert` (combinational):
  - Inputs: shifted buffer, offset f, `inData`, n.
  - Output: merged 128-bit buffer with byte masking.
- The top level holds the FSM, `fill` and `outAddr` counters, and handshake logic.

## Test plan
- Sustained full beats: 4 beats of 8 bytes 0x00..0x1F, `outReady`=1 → words 0x0706…00, 0x0F0E…08, … at `outAddr` 0..3, one per cycle. The last beat has `inLast`=1, so `done` pulses 1 cycle after word 3; `fill`=0.
- Row pattern 8,8,6,8 bytes (values 1..30), `inLast` on the 4th beat → 4 words:
  - Word 2 = bytes 17..24 (6 from beat 3, 2 from beat 4).
  - Word 3 = bytes 25..30 followed by 2 zero bytes.
  - `done` pulses once.
- Backpressure: `outReady`=0 while 3 full beats are offered → `inReady` drops after 2 accepts (`fill`=16). `outData`/`outAddr` stay stable. Release gives words 0, 1, then accept of beat 3.
- Edge inputs: `inBytes`=0 with `inLast` on an empty packer → no word, `done` 2 cycles later. `inBytes`=12 is packed as 8. Bytes above n are masked to zero in the output.
- Abort and wrap: `clear` asserted mid-layer with `fill`=5 → next cycle `outValid`=0, `inReady`=1, `outAddr`=0, no `done`. Separately, 2049 words give `outAddr` wrap 2047→0.

Source files
------------

// File: rtl/ofmap_packer_pkg.sv
// Shared constants, FSM encoding and byte-count helper for the ofmap write-back packer.
package ofmap_packer_pkg;

  localparam int WORD_W    = 64;
  localparam int BUF_W     = 128;
  localparam int FILL_W    = 5;
  localparam int MAX_BYTES = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A beat never carries more than one word of payload; larger counts saturate.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] raw);
    logic [3:0] res;
    if (raw > 4'd8) begin
      res = 4'd8;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/ofmap_byte_insert.sv
// Merges the first n bytes of a beat into the packing buffer at byte offset f.
module ofmap_byte_insert
  import ofmap_packer_pkg::*;
(
  input  logic [BUF_W-1:0]  buf_in,
  input  logic [FILL_W-1:0] offset,
  input  logic [WORD_W-1:0] data,
  input  logic [3:0]        nbytes,
  output logic [BUF_W-1:0]  buf_out
);

  logic [WORD_W-1:0] byte_mask;
  logic [BUF_W-1:0]  wide_mask;
  logic [BUF_W-1:0]  wide_data;
  logic [7:0]        shamt;

  // One 0xFF lane per valid byte; lanes at or above nbytes stay clear.
  always_comb begin
    byte_mask = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (4'(k) < nbytes) begin
        byte_mask[8*k +: 8] = 8'hFF;
      end else begin
        byte_mask[8*k +: 8] = 8'h00;
      end
    end
  end

  assign shamt     = {offset, 3'b000};
  assign wide_mask = {64'd0, byte_mask} << shamt;
  assign wide_data = {64'd0, data & byte_mask} << shamt;
  assign buf_out   = (buf_in & ~wide_mask) | wide_data;

endmodule

// File: rtl/ofmap_packer.sv
// Packs 0..8-byte ofmap segments LSB-first into 64-bit DRAM words, flushing a
// zero-padded residue word at end of layer and pulsing done afterwards.
module ofmap_packer
  import ofmap_packer_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inValid,
  input  logic [63:0]       inData,
  input  logic [3:0]        inBytes,
  input  logic              inLast,
  output logic              inReady,
  output logic              outValid,
  output logic [63:0]       outData,
  output logic [ADDR_W-1:0] outAddr,
  input  logic              outReady,
  output logic              done
);

  state_t             state;
  logic [BUF_W-1:0]   buffer;
  logic [FILL_W-1:0]  fill;
  logic [ADDR_W-1:0]  addr;

  logic               in_fire;
  logic               out_fire;
  logic [3:0]         n;
  logic [BUF_W-1:0]   shifted;
  logic [BUF_W-1:0]   merged;
  logic [BUF_W-1:0]   buffer_nxt;
  logic [FILL_W-1:0]  fill_post;
  logic [FILL_W-1:0]  fill_nxt;

  assign inReady  = (state == RUN) && (fill <= 5'd8);
  assign outValid = (fill >= 5'd8) || ((state == FLUSH) && (fill != 5'd0));
  assign outData  = buffer[WORD_W-1:0];
  assign outAddr  = addr;

  // The outgoing word is retired before the incoming beat lands, so a
  // simultaneous accept inserts at fill-8 and nothing overlaps.
  always_comb begin
    in_fire  = inValid && inReady;
    out_fire = outValid && outReady;
    n        = clamp_bytes(inBytes);
    if (out_fire) begin
      shifted = buffer >> WORD_W;
      if (fill > 5'd8) begin
        fill_post = fill - 5'd8;
      end else begin
        fill_post = 5'd0;
      end
    end else begin
      shifted   = buffer;
      fill_post = fill;
    end
    if (in_fire) begin
      buffer_nxt = merged;
      fill_nxt   = fill_post + {1'b0, n};
    end else begin
      buffer_nxt = shifted;
      fill_nxt   = fill_post;
    end
  end

  ofmap_byte_insert u_insert (
    .buf_in  (shifted),
    .offset  (fill_post),
    .data    (inData),
    .nbytes  (n),
    .buf_out (merged)
  );

  // Datapath registers, word index and the RUN/FLUSH/DONE sequencer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state  <= RUN;
      buffer <= '0;
      fill   <= '0;
      addr   <= '0;
      done   <= 1'b0;
    end else begin
      buffer <= buffer_nxt;
      fill   <= fill_nxt;
      done   <= 1'b0;
      if (out_fire) begin
        addr <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      case (state)
        RUN: begin
          if (in_fire && inLast) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (fill_nxt == 5'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= RUN;
          addr  <= '0;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_packer.sv
// Scoreboard bench for ofmap_packer: a byte-queue reference model predicts words
// and the done pulse; an independent monitor compares them as the DUT emits.
module tb_ofmap_packer;

  logic        clk = 1'b0;
  logic        rst, clear, inValid, inLast, inReady, outValid, outReady, done;
  logic [63:0] inData, outData;
  logic [3:0]  inBytes;
  logic [10:0] outAddr;

  always #5 clk = ~clk;

  ofmap_packer #(.ADDR_W(11)) dut (
    .clk(clk), .rst(rst), .clear(clear), .inValid(inValid), .inData(inData),
    .inBytes(inBytes), .inLast(inLast), .inReady(inReady), .outValid(outValid),
    .outData(outData), .outAddr(outAddr), .outReady(outReady), .done(done)
  );

  typedef struct {
    logic [63:0] data;
    logic [10:0] addr;
  } word_t;

  word_t       expq[$];
  logic [7:0]  mbytes[$];
  logic [10:0] maddr = 11'd0;
  int gen_count = 0, words_total = 0, out_count = 0;
  int last_edge = 0, last_pop_edge = 0, cyc = 0;
  bit pending = 1'b0;
  int checks = 0, passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_word();
    word_t w;
    w.data = '0;
    for (int i = 0; i < 8; i++)
      if (mbytes.size() > 0) w.data[8*i +: 8] = mbytes.pop_front();
    w.addr = maddr;
    expq.push_back(w);
    maddr = maddr + 11'd1;
    gen_count++;
  endtask

  // Reference: bytes form one stream; every 8 become a word, the layer tail is padded.
  task automatic model_accept(input logic [63:0] d, input logic [3:0] b, input logic l);
    int n;
    n = (b > 4'd8) ? 8 : int'(b);
    for (int i = 0; i < n; i++) mbytes.push_back(d[8*i +: 8]);
    while (mbytes.size() >= 8) push_word();
    if (l) begin
      if (mbytes.size() > 0) push_word();
      words_total = gen_count;
      gen_count   = 0;
      pending     = 1'b1;
      last_edge   = cyc + 1;
      maddr       = 11'd0;
    end
  endtask

  task automatic clear_model();
    mbytes.delete();
    expq.delete();
    maddr = 11'd0;
    gen_count = 0;
    out_count = 0;
    last_pop_edge = 0;
    pending = 1'b0;
  endtask

  // Called just after a rising edge; ends just after the next one.
  task automatic drive_cycle(input logic v, input logic [63:0] d, input logic [3:0] b,
                             input logic l, input logic r, output bit acc);
    inValid  = v;
    inData   = d;
    inBytes  = b;
    inLast   = l;
    outReady = r;
    @(negedge clk);
    acc = v && inReady;
    if (acc) model_accept(d, b, l);
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [3:0] b, input logic l, input bit rnd);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      drive_cycle(1'b1, d, b, l, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
      tries++;
    end
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: beat not accepted after %0d cycles, required acceptance", tries);
    end
  endtask

  task automatic idle(input int k, input bit rnd);
    bit acc;
    for (int i = 0; i < k; i++)
      drive_cycle(1'b0, 64'h0, 4'h0, 1'b0, rnd ? ($urandom_range(0, 1) != 0) : 1'b1, acc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || pending) && t < 400) begin
      idle(1, 1'b0);
      t++;
    end
    if (expq.size() != 0 || pending) begin
      checks++;
      $display("FAIL drain_timeout: %0d words still expected, pending done %0d", expq.size(), pending);
    end
  endtask

  task automatic wait_done(output int t);
    bit acc;
    t = 0;
    while (!done && t < 20) begin
      drive_cycle(1'b0, 64'h0, 4'h0, 1'b0, 1'b1, acc);
      t++;
    end
  endtask

  // Monitor: mid-cycle sampling of the output handshake and the done pulse.
  initial begin
    word_t w;
    int    dc;
    bit    exp_d;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && !clear) begin
        if (outValid && outReady) begin
          if (expq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got %h at addr %0d, required no word", outData, outAddr);
          end else begin
            w = expq.pop_front();
            chk("word_data", outData, w.data);
            chk("word_addr", 64'(outAddr), 64'(w.addr));
          end
          out_count++;
          last_pop_edge = cyc + 1;
        end
        exp_d = 1'b0;
        if (pending && out_count == words_total) begin
          dc = (last_pop_edge > last_edge + 1) ? last_pop_edge : last_edge + 1;
          exp_d = (cyc == dc);
        end
        if (done || exp_d) begin
          chk("done_pulse", 64'(done), 64'(exp_d));
          if (exp_d) begin
            pending = 1'b0;
            out_count = 0;
            last_pop_edge = 0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [63:0] bp [3];
    bit acc;
    int t, c0, acc_cnt, k, v, nb;

    rst = 1'b1; clear = 1'b0; inValid = 1'b0; inData = '0; inBytes = '0;
    inLast = 1'b0; outReady = 1'b0;
    @(posedge clk); #1;
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_outData",  outData,       64'd0);
    chk("rst_inReady",  64'(inReady),  64'd1);
    chk("rst_outAddr",  64'(outAddr),  64'd0);
    chk("rst_done",     64'(done),     64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sustained full beats 0x00..0x1F: one word per cycle, done right after word 3.
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(8*i + j);
      send_beat(d, 4'd8, i == 3, 1'b0);
      if (i == 0) chk("t1_first_word_latency", 64'(outValid), 64'd1);
    end
    chk("t1_throughput_cycles", 64'(cyc - c0), 64'd4);
    wait_done(t);
    chk("t1_done_latency", 64'(t), 64'd1);
    drain();

    // Row pattern 8,8,6,8 carrying 1..30; junk above the valid bytes of beat 3.
    v = 1;
    for (int i = 0; i < 4; i++) begin
      nb = (i == 2) ? 6 : 8;
      d = {64{1'b1}} & 64'hEEEE_EEEE_EEEE_EEEE;
      for (int j = 0; j < nb; j++) begin
        d[8*j +: 8] = 8'(v);
        v++;
      end
      send_beat(d, 4'(nb), i == 3, 1'b1);
    end
    drain();

    // Backpressure: only two full beats fit while the DRAM side stalls.
    for (int i = 0; i < 3; i++) bp[i] = {$urandom, $urandom};
    k = 0;
    acc_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b1, bp[k], 4'd8, k == 2, 1'b0, acc);
      if (acc) begin
        acc_cnt++;
        if (k < 2) k++;
      end
    end
    chk("bp_accepts",  64'(acc_cnt),  64'd2);
    chk("bp_inReady",  64'(inReady),  64'd0);
    chk("bp_outValid", 64'(outValid), 64'd1);
    chk("bp_outData",  outData,       bp[0]);
    chk("bp_outAddr",  64'(outAddr),  64'd0);
    send_beat(bp[2], 4'd8, 1'b1, 1'b0);
    drain();

    // Empty layer end, then an oversized count that must pack as 8 bytes.
    send_beat({$urandom, $urandom}, 4'd0, 1'b1, 1'b0);
    wait_done(t);
    chk("empty_done_latency", 64'(t), 64'd1);
    drain();
    send_beat({$urandom, $urandom}, 4'd12, 1'b0, 1'b0);
    send_beat({$urandom, $urandom}, 4'd3, 1'b1, 1'b0);
    drain();

    // Abort mid-layer with 5 bytes buffered and the word index at 2.
    send_beat({$urandom, $urandom}, 4'd8, 1'b0, 1'b0);
    send_beat({$urandom, $urandom}, 4'd8, 1'b0, 1'b0);
    send_beat({$urandom, $urandom}, 4'd5, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("pre_clear_outAddr", 64'(outAddr), 64'd2);
    clear = 1'b1;
    drive_cycle(1'b0, 64'h0, 4'h0, 1'b0, 1'b1, acc);
    clear = 1'b0;
    clear_model();
    chk("clear_outValid", 64'(outValid), 64'd0);
    chk("clear_inReady",  64'(inReady),  64'd1);
    chk("clear_outAddr",  64'(outAddr),  64'd0);
    idle(4, 1'b0);
    send_beat({$urandom, $urandom}, 4'd3, 1'b1, 1'b0);
    drain();

    // Randomised layers with idle gaps and random DRAM backpressure.
    for (int l = 0; l < 8; l++) begin
      nb = $urandom_range(1, 12);
      for (int j = 0; j < nb; j++) begin
        idle($urandom_range(0, 2), 1'b1);
        send_beat({$urandom, $urandom}, 4'($urandom_range(0, 15)), j == nb - 1, 1'b1);
      end
      drain();
    end

    // 2049 words: the word index wraps 2047 -> 0 within one layer.
    for (int i = 0; i < 2049; i++)
      send_beat({$urandom, $urandom}, 4'd8, i == 2048, 1'b0);
    drain();

    idle(3, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
